// File: rtl/rv32i_types_pkg.sv
// Shared RV32 execute-stage types: muldiv op codes, FSM states, operand-prep bundle.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package rv32i_types;

    localparam int MULDIV_ITERS = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3,
        F3_DIV    = 3'd4,
        F3_DIVU   = 3'd5,
        F3_REM    = 3'd6,
        F3_REMU   = 3'd7
    } muldiv_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    // Magnitudes, result-sign flags and special-case detects for one op.
    typedef struct packed {
        logic [31:0] a_abs;
        logic [31:0] b_abs;
        logic        prod_neg;   // product and quotient sign
        logic        rem_neg;    // remainder takes the dividend's sign
        logic        div_zero;
        logic        div_ovf;
    } prep_t;

    function automatic logic [31:0] neg32(input logic [31:0] x, input logic en);
        return en ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Operand conditioning for muldiv_unit: magnitudes, sign flags, div-by-zero/overflow detect.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
// Ports: funct3 (RV32M op), rs1_data/rs2_data (raw operands) -> prep (prep_t bundle).
module muldiv_operand_prep
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output prep_t       prep
);

    muldiv_funct3_t op;
    logic           a_sgn;
    logic           b_sgn;
    logic           a_neg;
    logic           b_neg;

    always_comb begin
        op    = muldiv_funct3_t'(funct3);
        // MUL keeps its low half regardless of signedness, so it is treated as unsigned.
        a_sgn = (op == F3_MULH) || (op == F3_MULHSU) || (op == F3_DIV) || (op == F3_REM);
        b_sgn = (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
        a_neg = a_sgn && rs1_data[31];
        b_neg = b_sgn && rs2_data[31];

        prep          = '0;
        prep.a_abs    = neg32(rs1_data, a_neg);
        prep.b_abs    = neg32(rs2_data, b_neg);
        prep.prod_neg = a_neg ^ b_neg;
        prep.rem_neg  = a_neg;
        prep.div_zero = funct3[2] && (rs2_data == 32'd0);
        prep.div_ovf  = ((op == F3_DIV) || (op == F3_REM)) &&
                        (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Latency: done 33 clocks after accept; div-by-zero/overflow (and muls with MULDIV_FAST_MUL_EN) 1 clock.
// Backpressure: busy high in CALC/DONE; start ignored unless IDLE, no queueing; flush aborts.
// Ports: clk, rst (sync, active-high), start, funct3, rs1_data, rs2_data, flush -> busy, done, result.
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle 33x33 signed multiplier for MUL*.
// Only width = 32 is supported.
module muldiv_unit
    import rv32i_types::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [width-1:0] rs1_data,
    input  logic [width-1:0] rs2_data,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] result
);

    localparam logic [4:0] LAST_ITER = 5'(MULDIV_ITERS - 1);

    muldiv_state_t  state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    muldiv_funct3_t op_q, op_d;
    logic [31:0]    opb_q, opb_d;     // multiplicand for mul, divisor for div
    logic [63:0]    acc_q, acc_d;     // mul: {partial hi, multiplier}; div: {remainder, quotient}
    logic           prod_neg_q, prod_neg_d;
    logic           rem_neg_q, rem_neg_d;
    logic [31:0]    result_q, result_d;

    prep_t          prep;
    logic [32:0]    add_sum;
    logic [32:0]    sub_diff;
    logic [63:0]    acc_step;
    logic [63:0]    prod_fix;
    logic [31:0]    calc_res;
    logic [31:0]    spec_res;
    logic           fast_hit;
    logic [31:0]    fast_res;

    muldiv_operand_prep u_prep (
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .prep     (prep)
    );

    // One iteration of the datapath; the last CALC cycle also feeds the result mux.
    always_comb begin
        add_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        sub_diff = acc_q[63:31] - {1'b0, opb_q};
        if (!op_q[2]) begin
            acc_step = {add_sum, acc_q[31:1]};
        end else if (!sub_diff[32]) begin
            acc_step = {sub_diff[31:0], acc_q[30:0], 1'b1};
        end else begin
            acc_step = {acc_q[62:0], 1'b0};
        end

        prod_fix = prod_neg_q ? (~acc_step + 64'd1) : acc_step;
        case (op_q)
            F3_MUL:                       calc_res = prod_fix[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU: calc_res = prod_fix[63:32];
            F3_DIV, F3_DIVU:              calc_res = neg32(acc_step[31:0], prod_neg_q);
            default:                      calc_res = neg32(acc_step[63:32], rem_neg_q);
        endcase

        // funct3[1] separates REM/REMU from DIV/DIVU.
        if (prep.div_zero) begin
            spec_res = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
        end else begin
            spec_res = funct3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [32:0] fast_a;
    logic signed [32:0] fast_b;
    logic signed [65:0] fast_prod;

    always_comb begin
        fast_a    = {((funct3 == F3_MULH) || (funct3 == F3_MULHSU)) && rs1_data[31], rs1_data};
        fast_b    = {(funct3 == F3_MULH) && rs2_data[31], rs2_data};
        fast_prod = fast_a * fast_b;
        fast_hit  = !funct3[2];
        fast_res  = (funct3 == F3_MUL) ? fast_prod[31:0] : fast_prod[63:32];
    end
`else
    always_comb begin
        fast_hit = 1'b0;
        fast_res = 32'd0;
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        opb_d      = opb_q;
        acc_d      = acc_q;
        prod_neg_d = prod_neg_q;
        rem_neg_d  = rem_neg_q;
        result_d   = result_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d       = muldiv_funct3_t'(funct3);
                    opb_d      = funct3[2] ? prep.b_abs : prep.a_abs;
                    acc_d      = {32'd0, funct3[2] ? prep.a_abs : prep.b_abs};
                    prod_neg_d = prep.prod_neg;
                    rem_neg_d  = prep.rem_neg;
                    cnt_d      = 5'd0;
                    if (fast_hit) begin
                        result_d = fast_res;
                        state_d  = DONE;
                    end else if (prep.div_zero || prep.div_ovf) begin
                        result_d = spec_res;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    result_d = calc_res;
                    state_d  = DONE;
                end
            end
            DONE: begin
                cnt_d   = 5'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Redirect abort: drop whatever was computed, keep the last good result.
        if (flush) begin
            state_d  = IDLE;
            cnt_d    = 5'd0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            op_q       <= F3_MUL;
            opb_q      <= 32'd0;
            acc_q      <= 64'd0;
            prod_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            result_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            opb_q      <= opb_d;
            acc_q      <= acc_d;
            prod_neg_q <= prod_neg_d;
            rem_neg_q  <= rem_neg_d;
            result_q   <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE) && !flush;
    assign result = result_q;

endmodule
